// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and default sizes for the register-file dump reader.
package regdump_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    CSUM,
    DONE
  } state_e;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output stream of the dump reader: one word per valid/ready handshake.
//   out_valid/out_data/out_index/out_last : producer -> consumer
//   out_ready                             : consumer -> producer
interface regfile_dump_reader_if #(
  parameter int unsigned DATA_WIDTH = regdump_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regdump_pkg::ADDR_WIDTH
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  modport master (
    output out_valid, out_data, out_index, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_index, out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader_out_reg.sv
// Stream output register for the dump reader.
//   clock, reset : clock and synchronous active-high reset
//   load, ld_*   : capture a new word and raise valid
//   ready        : consumer ready; valid drops after a handshake
//   valid, data, index, last : registered stream outputs
module regdump_out_reg
  import regdump_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = regdump_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regdump_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [ADDR_WIDTH-1:0] ld_index,
  input  logic                  ld_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  last
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  last_q, last_d;

  // A load in the same cycle as a handshake wins, so a follow-on word
  // can be presented back-to-back.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      index_d = ld_index;
      last_d  = ld_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign index = index_q;
  assign last  = last_q;
endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: on start, walks every register through the
// shared read port and streams each word out tagged with its index.
//   clock, reset : clock and synchronous active-high reset
//   start        : begin a dump (accepted only when idle)
//   rd_addr      : read-port address; rd_data is its combinational data
//   out_if       : output stream (valid/ready, data, index, last)
//   busy         : dump in progress; done : one-cycle completion pulse
// Build option REGDUMP_CHECKSUM_EN appends a checksum word (sum of all
// captured words) after the last register.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int unsigned NUM_REGS   = regdump_pkg::NUM_REGS,
  parameter int unsigned DATA_WIDTH = regdump_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = regdump_pkg::ADDR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  regfile_dump_reader_if.master  out_if,
  output logic                   busy,
  output logic                   done
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  hs;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic [ADDR_WIDTH-1:0] load_index;
  logic                  load_last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
`endif

  assign hs = out_if.out_valid && out_if.out_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_addr    = '0;
    load       = 1'b0;
    load_data  = rd_data;
    load_index = idx_q;
`ifdef REGDUMP_CHECKSUM_EN
    acc_d      = acc_q;
    load_last  = 1'b0;
`else
    load_last  = (idx_q == LAST_IDX);
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = READ;
`ifdef REGDUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      READ: begin
        rd_addr = idx_q;
        load    = 1'b1;
        state_d = SEND;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d   = acc_q + rd_data;
`endif
      end
      SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
            // Checksum word is loaded on the last register's handshake.
            load       = 1'b1;
            load_data  = acc_q;
            load_index = '0;
            load_last  = 1'b1;
            state_d    = CSUM;
`else
            state_d    = DONE;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = READ;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        if (hs) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef REGDUMP_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  regdump_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_out_reg (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .ld_data  (load_data),
    .ld_index (load_index),
    .ld_last  (load_last),
    .ready    (out_if.out_ready),
    .valid    (out_if.out_valid),
    .data     (out_if.out_data),
    .index    (out_if.out_index),
    .last     (out_if.out_last)
  );
endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
  import regdump_pkg::*;

  localparam int unsigned NR = regdump_pkg::NUM_REGS;
  localparam int unsigned DW = regdump_pkg::DATA_WIDTH;
  localparam int unsigned AW = regdump_pkg::ADDR_WIDTH;
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] index;
    logic          last;
  } word_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] regs [NR];

  regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_dump_reader #(
    .NUM_REGS   (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .out_if  (bus.master),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  // Register file model: x0 always reads zero.
  assign rd_data = (rd_addr == '0) ? '0 : regs[rd_addr];

  word_t exp_q [$];
  int    checks = 0;
  int    errors = 0;
  int    n_popped = 0;
  int    ready_mode = 0;
  int    stall_cnt = 0;
  bit    stalled = 1'b0;
  word_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every handshaken word with the scoreboard and checks
  // that a stalled word is held unchanged.
  always @(negedge clock) begin
    word_t cur;
    word_t exp_w;
    cur = {bus.out_data, bus.out_index, bus.out_last};
    if (!reset) begin
      if (stalled) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_word", 64'(cur), 64'(held));
      end
      if (bus.out_valid) check("busy_while_valid", 64'(busy), 64'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h expected none", cur);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", 64'(cur), 64'(exp_w));
          n_popped++;
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = cur;
    end else begin
      stalled = 1'b0;
    end
  end

  // Consumer ready generator.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.out_valid && bus.out_index == AW'(5) && stall_cnt < 3) begin
            bus.out_ready = 1'b0;
            stall_cnt++;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = !(bus.out_valid && bus.out_index == AW'(17));
      endcase
    end
  end

  task automatic fill_regs(input bit identity);
    for (int i = 0; i < int'(NR); i++) regs[i] = identity ? DW'(i) : DW'($urandom);
  endtask

  // Expected stream: every register as seen by the reader, then (optionally)
  // the modular sum of those words.
  task automatic push_expected();
    logic [DW-1:0] sum;
    word_t w;
    sum = '0;
    for (int i = 0; i < int'(NR); i++) begin
      w.data  = (i == 0) ? '0 : regs[i];
      w.index = AW'(i);
      w.last  = (i == int'(NR) - 1) && !CSUM_EN;
      sum     = sum + w.data;
      exp_q.push_back(w);
    end
    if (CSUM_EN) begin
      w.data  = sum;
      w.index = '0;
      w.last  = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic start_dump();
    check("queue_empty_at_start", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    n_popped = 0;
    push_expected();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; lat counts cycles after accept.
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clock);
      lat++;
      if (done) break;
      if (lat > 3000) begin
        check("done_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  task automatic finish_dump_checks();
    check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_index(input int idx);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      n++;
      if (bus.out_valid && bus.out_index == AW'(idx)) break;
      if (n > 3000) begin
        check("index_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pos;
    int n;
    logic [DW-1:0] delta;
    reset = 1'b1;
    start = 1'b0;
    fill_regs(1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_index", 64'(bus.out_index), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    check("rst_addr", 64'(rd_addr), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Identity dump at full rate: minimum latency.
    ready_mode = 0;
    start_dump();
    wait_done(lat);
    check("dump_latency", 64'(lat), 64'(2 * NR + 1 + (CSUM_EN ? 1 : 0)));
    finish_dump_checks();

    // Consumer stalls three cycles on index 5.
    ready_mode = 2;
    stall_cnt  = 0;
    start_dump();
    wait_done(lat);
    check("stall_cycles", 64'(stall_cnt), 64'd3);
    finish_dump_checks();

    // Start pulses mid-dump and in DONE are ignored.
    ready_mode = 0;
    fill_regs(1'b0);
    start_dump();
    wait_index(10);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(lat);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("no_restart_busy", 64'(busy), 64'd0);
      check("no_restart_valid", 64'(bus.out_valid), 64'd0);
    end

    // Reset while stalled in SEND at index 17, then a fresh dump.
    ready_mode = 3;
    start_dump();
    wait_index(17);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_index", 64'(bus.out_index), 64'd0);
    check("midrst_data", 64'(bus.out_data), 64'd0);
    check("midrst_last", 64'(bus.out_last), 64'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    ready_mode = 1;
    fill_regs(1'b0);
    start_dump();
    wait_done(lat);
    finish_dump_checks();

    // Core writes x20 while the dump is at index 5 (0..4 already sent).
    ready_mode = 0;
    fill_regs(1'b1);
    start_dump();
    n = 0;
    while (n_popped < 5 && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("reach_index5", 64'(n_popped), 64'd5);
    pos   = 20 - n_popped;
    delta = 32'hDEADBEEF - exp_q[pos].data;
    regs[20] = 32'hDEADBEEF;
    exp_q[pos].data = 32'hDEADBEEF;
    if (CSUM_EN) exp_q[exp_q.size() - 1].data = exp_q[exp_q.size() - 1].data + delta;
    wait_done(lat);
    finish_dump_checks();

    // Random contents with random back-pressure.
    ready_mode = 1;
    for (int k = 0; k < 3; k++) begin
      fill_regs(1'b0);
      start_dump();
      wait_done(lat);
      finish_dump_checks();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
